// File: rtl/mem_writeback_align.sv
// Writeback aligner after MEM stage 3: per-lane word crossbar feeding a
// small result queue that yields the RF write port to the ALU.
module mem_writeback_align #(
    parameter int FIFO_DEPTH  = 4,
    parameter int AFULL_LEVEL = 3
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic         reg_write_i,
    input  logic         write_fb_valid_i,
    input  logic [2:0]   warp_ID_i,
    input  logic [1:0]   scb_ID_i,
    input  logic [255:0] read_data_i,
    input  logic [4:0]   reg_addr_i,
    input  logic [7:0]   thread_mask_i,
    input  logic [23:0]  word_offset_i,
    input  logic [31:0]  Instr_i,
    input  logic         alu_wen_i,
    output logic         rf_wen_o,
    output logic [2:0]   rf_warp_o,
    output logic [4:0]   rf_addr_o,
    output logic [7:0]   rf_mask_o,
    output logic [255:0] rf_data_o,
    output logic         scb_clr_valid_o,
    output logic [2:0]   scb_clr_warp_o,
    output logic [1:0]   scb_clr_id_o,
    output logic [31:0]  Instr_o,
    output logic         mem_afull_o,
    output logic         overflow_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic         is_load;
        logic [2:0]   warp;
        logic [1:0]   scb;
        logic [4:0]   rg;
        logic [7:0]   mask;
        logic [255:0] data;
        logic [31:0]  instr;
    } wb_entry_t;

    wb_entry_t        mem [FIFO_DEPTH];
    wb_entry_t        push_ent;
    wb_entry_t        head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [255:0]     aligned;
    logic [2:0]       sel;
    logic             push_req;
    logic             full;
    logic             empty;
    logic             pop;
    logic             push;

    // Stores carry no data, so only loads drive the crossbar.
    always_comb begin
        aligned = '0;
        sel     = '0;
        for (int i = 0; i < 8; i++) begin
            sel = word_offset_i[3*i +: 3];
            if (reg_write_i && thread_mask_i[i])
                aligned[32*i +: 32] = read_data_i[{sel, 5'd0} +: 32];
        end
    end

    assign push_req = reg_write_i | write_fb_valid_i;
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign head     = mem[rd_ptr];
    assign pop      = !empty && (!head.is_load || !alu_wen_i);
    // A pop in the same edge frees a slot for a push into a full queue.
    assign push     = push_req && (!full || pop);

    always_comb begin
        push_ent.is_load = reg_write_i;
        push_ent.warp    = warp_ID_i;
        push_ent.scb     = scb_ID_i;
        push_ent.rg      = reg_addr_i;
        push_ent.mask    = thread_mask_i;
        push_ent.data    = aligned;
        push_ent.instr   = Instr_i;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_ent;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
            if (push_req && !push)
                overflow_o <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            rf_wen_o        <= 1'b0;
            rf_warp_o       <= '0;
            rf_addr_o       <= '0;
            rf_mask_o       <= '0;
            rf_data_o       <= '0;
            scb_clr_valid_o <= 1'b0;
            scb_clr_warp_o  <= '0;
            scb_clr_id_o    <= '0;
            Instr_o         <= '0;
        end else begin
            rf_wen_o        <= pop && head.is_load;
            scb_clr_valid_o <= pop;
            if (pop) begin
                scb_clr_warp_o <= head.warp;
                scb_clr_id_o   <= head.scb;
                Instr_o        <= head.instr;
            end
            if (pop && head.is_load) begin
                rf_warp_o <= head.warp;
                rf_addr_o <= head.rg;
                rf_mask_o <= head.mask;
                rf_data_o <= head.data;
            end
        end
    end

    assign mem_afull_o = (count >= CNT_W'(AFULL_LEVEL));

endmodule

// File: tb/tb_mem_writeback_align.sv
// Bench for mem_writeback_align: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_mem_writeback_align;

    logic         clk = 1'b0;
    logic         resetb;
    logic         reg_write_i;
    logic         write_fb_valid_i;
    logic [2:0]   warp_ID_i;
    logic [1:0]   scb_ID_i;
    logic [255:0] read_data_i;
    logic [4:0]   reg_addr_i;
    logic [7:0]   thread_mask_i;
    logic [23:0]  word_offset_i;
    logic [31:0]  Instr_i;
    logic         alu_wen_i;
    logic         rf_wen_o;
    logic [2:0]   rf_warp_o;
    logic [4:0]   rf_addr_o;
    logic [7:0]   rf_mask_o;
    logic [255:0] rf_data_o;
    logic         scb_clr_valid_o;
    logic [2:0]   scb_clr_warp_o;
    logic [1:0]   scb_clr_id_o;
    logic [31:0]  Instr_o;
    logic         mem_afull_o;
    logic         overflow_o;

    mem_writeback_align #(.FIFO_DEPTH(4), .AFULL_LEVEL(3)) dut (
        .clk(clk), .resetb(resetb),
        .reg_write_i(reg_write_i),
        .write_fb_valid_i(write_fb_valid_i),
        .warp_ID_i(warp_ID_i), .scb_ID_i(scb_ID_i),
        .read_data_i(read_data_i), .reg_addr_i(reg_addr_i),
        .thread_mask_i(thread_mask_i),
        .word_offset_i(word_offset_i),
        .Instr_i(Instr_i), .alu_wen_i(alu_wen_i),
        .rf_wen_o(rf_wen_o), .rf_warp_o(rf_warp_o),
        .rf_addr_o(rf_addr_o), .rf_mask_o(rf_mask_o),
        .rf_data_o(rf_data_o),
        .scb_clr_valid_o(scb_clr_valid_o),
        .scb_clr_warp_o(scb_clr_warp_o),
        .scb_clr_id_o(scb_clr_id_o),
        .Instr_o(Instr_o), .mem_afull_o(mem_afull_o),
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         ld;
        bit [2:0]   warp;
        bit [1:0]   scb;
        bit [4:0]   rg;
        bit [7:0]   mask;
        bit [255:0] data;
        bit [31:0]  instr;
    } ent_t;

    ent_t         q[$];
    int           n_vec = 0;
    int           n_err = 0;
    bit           e_wen, e_sv, e_ovf;
    bit [2:0]     e_warp, e_sw;
    bit [4:0]     e_addr;
    bit [7:0]     e_mask;
    bit [255:0]   e_data;
    bit [1:0]     e_sid;
    bit [31:0]    e_instr;
    logic [255:0] line;
    logic [23:0]  offs;

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    function automatic bit [255:0] ref_align(bit [255:0] ln,
                                             bit [23:0] of,
                                             bit [7:0] mk);
        bit [31:0]  w[8];
        bit [255:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) w[k] = ln[32*k +: 32];
        for (int i = 0; i < 8; i++)
            if (mk[i]) r[32*i +: 32] = w[of[3*i +: 3]];
        return r;
    endfunction

    task automatic model_edge();
        ent_t e;
        if (q.size() > 0 && (!q[0].ld || !alu_wen_i)) begin
            e = q.pop_front();
            e_sv = 1; e_sw = e.warp; e_sid = e.scb;
            e_instr = e.instr;
            e_wen = e.ld;
            if (e.ld) begin
                e_warp = e.warp; e_addr = e.rg;
                e_mask = e.mask; e_data = e.data;
            end
        end else begin
            e_sv = 0; e_wen = 0;
        end
        if (reg_write_i || write_fb_valid_i) begin
            if (q.size() < 4) begin
                e.ld = reg_write_i; e.warp = warp_ID_i;
                e.scb = scb_ID_i; e.rg = reg_addr_i;
                e.mask = thread_mask_i; e.instr = Instr_i;
                e.data = reg_write_i ?
                    ref_align(read_data_i, word_offset_i,
                              thread_mask_i) : '0;
                q.push_back(e);
            end else e_ovf = 1;
        end
    endtask

    task automatic check_outs();
        chk("rf_wen", 256'(rf_wen_o), 256'(e_wen));
        chk("scb_v", 256'(scb_clr_valid_o), 256'(e_sv));
        chk("afull", 256'(mem_afull_o), 256'(q.size() >= 3));
        chk("ovf", 256'(overflow_o), 256'(e_ovf));
        if (e_sv) begin
            chk("scb_warp", 256'(scb_clr_warp_o), 256'(e_sw));
            chk("scb_id", 256'(scb_clr_id_o), 256'(e_sid));
            chk("instr", 256'(Instr_o), 256'(e_instr));
        end
        if (e_wen) begin
            chk("rf_warp", 256'(rf_warp_o), 256'(e_warp));
            chk("rf_addr", 256'(rf_addr_o), 256'(e_addr));
            chk("rf_mask", 256'(rf_mask_o), 256'(e_mask));
            chk("rf_data", rf_data_o, e_data);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outs();
    endtask

    task automatic drive(bit rw, bit fb, bit [2:0] w, bit [1:0] s,
                         bit [4:0] r, bit [7:0] m, bit [31:0] ins);
        reg_write_i = rw; write_fb_valid_i = fb;
        warp_ID_i = w; scb_ID_i = s; reg_addr_i = r;
        thread_mask_i = m; Instr_i = ins;
        read_data_i = line; word_offset_i = offs;
    endtask

    task automatic idle();
        reg_write_i = 0; write_fb_valid_i = 0;
    endtask

    task automatic apply_reset();
        resetb = 0;
        #1;
        q.delete();
        e_wen = 0; e_sv = 0; e_ovf = 0; e_warp = 0; e_addr = 0;
        e_mask = 0; e_data = 0; e_sw = 0; e_sid = 0; e_instr = 0;
        chk("rst_wen", 256'(rf_wen_o), 256'(0));
        chk("rst_warp", 256'(rf_warp_o), 256'(0));
        chk("rst_addr", 256'(rf_addr_o), 256'(0));
        chk("rst_mask", 256'(rf_mask_o), 256'(0));
        chk("rst_data", rf_data_o, 256'(0));
        chk("rst_sv", 256'(scb_clr_valid_o), 256'(0));
        chk("rst_sw", 256'(scb_clr_warp_o), 256'(0));
        chk("rst_sid", 256'(scb_clr_id_o), 256'(0));
        chk("rst_instr", 256'(Instr_o), 256'(0));
        chk("rst_afull", 256'(mem_afull_o), 256'(0));
        chk("rst_ovf", 256'(overflow_o), 256'(0));
        @(negedge clk);
        resetb = 1;
    endtask

    initial begin
        idle();
        alu_wen_i = 0; warp_ID_i = 0; scb_ID_i = 0;
        reg_addr_i = 0; thread_mask_i = 0; Instr_i = 0;
        read_data_i = 0; word_offset_i = 0;
        for (int k = 0; k < 8; k++) line[32*k +: 32] = 32'h100 + k;
        for (int i = 0; i < 8; i++) offs[3*i +: 3] = 3'(7 - i);
        apply_reset();

        // Reversed-lane load, full mask: visible two edges later
        drive(1, 0, 3'd5, 2'd1, 5'd9, 8'hFF, 32'hA0);
        tick();
        idle();
        tick();
        chk("t1_wen", 256'(rf_wen_o), 256'(1));
        chk("t1_l0", 256'(rf_data_o[31:0]), 256'(32'h107));
        chk("t1_l7", 256'(rf_data_o[255:224]), 256'(32'h100));
        chk("t1_sw", 256'(scb_clr_warp_o), 256'(5));
        tick();

        drive(1, 0, 3'd1, 2'd0, 5'd4, 8'h0F, 32'hA1);
        tick(); idle(); tick();
        chk("t2_hi", rf_data_o[255:128], 256'(0));
        chk("t2_l3", 256'(rf_data_o[127:96]), 256'(32'h104));
        chk("t2_mask", 256'(rf_mask_o), 256'(8'h0F));
        tick();

        drive(0, 1, 3'd3, 2'd2, 5'd0, 8'h00, 32'hA2);
        tick(); idle(); tick();
        chk("t3_sv", 256'(scb_clr_valid_o), 256'(1));
        chk("t3_wen", 256'(rf_wen_o), 256'(0));
        chk("t3_sw", 256'(scb_clr_warp_o), 256'(3));
        chk("t3_sid", 256'(scb_clr_id_o), 256'(2));
        tick();

        // ALU holds the port while three loads queue up
        alu_wen_i = 1;
        for (int n = 1; n <= 3; n++) begin
            drive(1, 0, 3'(n), 2'(n), 5'(n), 8'hFF, 32'(n));
            tick();
        end
        idle();
        chk("t4_afull", 256'(mem_afull_o), 256'(1));
        alu_wen_i = 0;
        for (int n = 1; n <= 3; n++) begin
            tick();
            chk("t4_order", 256'(rf_addr_o), 256'(n));
        end
        chk("t4_afull0", 256'(mem_afull_o), 256'(0));
        tick();

        for (int c = 0; c < 400; c++) begin
            line = {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom};
            offs = 24'($urandom);
            drive(bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 2) == 0),
                  3'($urandom), 2'($urandom), 5'($urandom),
                  8'($urandom), $urandom);
            alu_wen_i = ($urandom_range(0, 9) < 4);
            tick();
        end
        idle(); alu_wen_i = 0;
        repeat (6) tick();

        apply_reset();
        // Store behind a stalled load, then flushed by reset
        alu_wen_i = 1;
        drive(1, 0, 3'd2, 2'd1, 5'd7, 8'hFF, 32'hB0);
        tick();
        drive(0, 1, 3'd6, 2'd3, 5'd0, 8'h00, 32'hB1);
        tick();
        idle();
        repeat (3) begin
            tick();
            chk("t6_nosv", 256'(scb_clr_valid_o), 256'(0));
        end
        apply_reset();
        alu_wen_i = 0;
        repeat (4) begin
            tick();
            chk("t6_flush", 256'({rf_wen_o, scb_clr_valid_o}), 256'(0));
        end

        alu_wen_i = 1;
        for (int n = 1; n <= 5; n++) begin
            drive(1, 0, 3'(n), 2'(n), 5'(10 + n), 8'hFF, 32'(n));
            tick();
        end
        idle();
        chk("t5_ovf", 256'(overflow_o), 256'(1));
        alu_wen_i = 0;
        for (int n = 1; n <= 4; n++) begin
            tick();
            chk("t5_drain", 256'(rf_addr_o), 256'(10 + n));
        end
        repeat (3) begin
            tick();
            chk("t5_no5th", 256'(rf_wen_o), 256'(0));
        end
        chk("t5_sticky", 256'(overflow_o), 256'(1));

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
